// File: rtl/sm_result_acc_fifo_if.sv
// sm_result_acc_fifo_if: valid/ready bus into and out of the result FIFO
interface sm_result_acc_fifo_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_sign;
   logic [8:0] in_mag;
   logic       out_valid;
   logic       out_ready;
   logic       out_sign;
   logic [8:0] out_mag;
   modport master (output in_valid, in_sign, in_mag, out_ready, input in_ready, out_valid, out_sign, out_mag);
   modport slave (input in_valid, in_sign, in_mag, out_ready, output in_ready, out_valid, out_sign, out_mag);
endinterface

// File: rtl/sm_result_acc_fifo.sv
// sm_result_acc_fifo: FWFT result FIFO with saturating running sum; ADDER_STATS_EN adds neg/nsat counters
module sm_result_acc_fifo #(
   parameter int DEPTH = 4,
   parameter int ACC_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sm_result_acc_fifo_if.slave     bus,
   input  logic                    clr,
   output logic [$clog2(DEPTH):0]  count,
   output logic signed [ACC_W-1:0] acc,
   output logic                    acc_sat
`ifdef ADDER_STATS_EN
   ,
   output logic [15:0]             neg_cnt,
   output logic [15:0]             nsat_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   logic [9:0]              mem_q [DEPTH];
   logic [AW-1:0]           wr_q, rd_q;
   logic [AW:0]             count_q, count_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    acc_sat_q, acc_sat_d;
   logic                    push, pop, n_sign, ovf;
   logic [8:0]              n_mag;
   logic signed [ACC_W:0]   v, sum;
   assign bus.in_ready  = count_q != (AW+1)'(DEPTH);
   assign bus.out_valid = count_q != '0;
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;
   assign {bus.out_sign, bus.out_mag} = bus.out_valid ? mem_q[rd_q] : 10'd0;
   assign count   = count_q;
   assign acc     = acc_q;
   assign acc_sat = acc_sat_q;
   // Sum is one bit wider than acc, so overflow shows as disagreeing top two bits
   always_comb begin
      n_sign    = bus.in_sign & (bus.in_mag != 9'd0);
      n_mag     = (bus.in_sign & (bus.in_mag > 9'd256)) ? 9'd256 :
                  (!bus.in_sign & (bus.in_mag > 9'd255)) ? 9'd255 : bus.in_mag;
      v         = n_sign ? -$signed({{(ACC_W-8){1'b0}}, n_mag}) : $signed({{(ACC_W-8){1'b0}}, n_mag});
      sum       = (clr ? {(ACC_W+1){1'b0}} : {acc_q[ACC_W-1], acc_q}) + v;
      ovf       = sum[ACC_W] != sum[ACC_W-1];
      count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
      acc_d     = push ? (ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0]) :
                  clr ? '0 : acc_q;
      acc_sat_d = (acc_sat_q & ~clr) | (push & ovf);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q      <= '0;
         rd_q      <= '0;
         count_q   <= '0;
         acc_q     <= '0;
         acc_sat_q <= 1'b0;
      end else begin
         wr_q      <= wr_q + AW'(push);
         rd_q      <= rd_q + AW'(pop);
         count_q   <= count_d;
         acc_q     <= acc_d;
         acc_sat_q <= acc_sat_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {n_sign, n_mag};
   end
`ifdef ADDER_STATS_EN
   logic [15:0] neg_q, nsat_q;
   logic        neg_ev, nsat_ev;
   assign neg_ev   = push & n_sign;
   assign nsat_ev  = neg_ev & (n_mag == 9'd256);
   assign neg_cnt  = neg_q;
   assign nsat_cnt = nsat_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q  <= '0;
         nsat_q <= '0;
      end else begin
         neg_q  <= (clr ? 16'd0 : neg_q) + 16'(neg_ev & (clr | (neg_q != 16'hFFFF)));
         nsat_q <= (clr ? 16'd0 : nsat_q) + 16'(nsat_ev & (clr | (nsat_q != 16'hFFFF)));
      end
   end
`endif
endmodule

// File: tb/tb_sm_result_acc_fifo.sv
// tb_sm_result_acc_fifo: scoreboard bench for the result FIFO and saturating accumulator
module tb_sm_result_acc_fifo;
   logic clk = 1'b0;
   logic rst_n;
   logic clr_a, clr_b;
   logic [2:0] count_a, count_b;
   logic signed [15:0] acc_a;
   logic signed [10:0] acc_b;
   logic sat_a, sat_b;
   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];
   sm_result_acc_fifo_if bus_a ();
   sm_result_acc_fifo_if bus_b ();
`ifdef ADDER_STATS_EN
   logic [15:0] neg_a, nsat_a, neg_b, nsat_b;
`endif

   always #5 clk = ~clk;

   sm_result_acc_fifo #(.DEPTH(4), .ACC_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a), .clr(clr_a),
      .count(count_a), .acc(acc_a), .acc_sat(sat_a)
`ifdef ADDER_STATS_EN
      , .neg_cnt(neg_a), .nsat_cnt(nsat_a)
`endif
   );

   sm_result_acc_fifo #(.DEPTH(4), .ACC_W(11)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b), .clr(clr_b),
      .count(count_b), .acc(acc_b), .acc_sat(sat_b)
`ifdef ADDER_STATS_EN
      , .neg_cnt(neg_b), .nsat_cnt(nsat_b)
`endif
   );

   function automatic logic [9:0] norm(input logic s, input logic [8:0] m);
      if (s && m == 9'd0) return 10'd0;
      if (!s && m > 9'd255) return {1'b0, 9'd255};
      if (s && m > 9'd256) return {1'b1, 9'd256};
      return {s, m};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake, records every accepted input
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_a.out_valid && bus_a.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got %0d expected none", {bus_a.out_sign, bus_a.out_mag});
            end else chk("sb_data", {bus_a.out_sign, bus_a.out_mag}, exp_q.pop_front());
         end
         if (bus_a.in_valid && bus_a.in_ready) exp_q.push_back(norm(bus_a.in_sign, bus_a.in_mag));
      end
   end

   task automatic push(input logic s, input logic [8:0] m);
      int n = 0;
      bus_a.in_valid = 1'b1;
      bus_a.in_sign  = s;
      bus_a.in_mag   = m;
      @(negedge clk);
      while (!bus_a.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("push_timeout", n, 0);
      @(posedge clk);
      #1 bus_a.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      bus_a.out_ready = 1'b1;
      while (count_a != 3'd0 && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("drain_count", int'(count_a), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      clr_a = 1'b0;
      clr_b = 1'b0;
      bus_a.in_valid = 1'b0; bus_a.in_sign = 1'b0; bus_a.in_mag = '0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_sign = 1'b0; bus_b.in_mag = '0; bus_b.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_out_valid", int'(bus_a.out_valid), 0);
      chk("rst_in_ready", int'(bus_a.in_ready), 1);
      chk("rst_count", int'(count_a), 0);
      chk("rst_acc", int'(acc_a), 0);
      chk("rst_out_mag", int'(bus_a.out_mag), 0);
      push(1'b0, 9'd5); push(1'b1, 9'd3); push(1'b0, 9'd200);
      chk("t1_count", int'(count_a), 3);
      chk("t1_head", int'({bus_a.out_sign, bus_a.out_mag}), 5);
      chk("t1_acc", int'(acc_a), 202);
      chk("t1_sat", int'(sat_a), 0);
      push(1'b0, 9'd7);
      chk("t2_full_ready", int'(bus_a.in_ready), 0);
      chk("t2_full_count", int'(count_a), 4);
      fork
         push(1'b1, 9'd9);
         begin
            repeat (3) @(posedge clk);
            #2 chk("t2_held_count", int'(count_a), 4);
            chk("t2_held_acc", int'(acc_a), 209);
            bus_a.out_ready = 1'b1;
         end
      join
      push(1'b0, 9'd1); push(1'b1, 9'd2); push(1'b0, 9'd3);
      chk("t3_acc", int'(acc_a), 202);
      drain();
      bus_a.out_ready = 1'b0;
      push(1'b1, 9'd0); push(1'b0, 9'd300);
      chk("t4_count", int'(count_a), 2);
      chk("t4_head", int'({bus_a.out_sign, bus_a.out_mag}), 0);
      chk("t4_acc", int'(acc_a), 457);
      bus_a.out_ready = 1'b1;
      push(1'b1, 9'd300);
      drain();
      chk("t4_neg_clamp_acc", int'(acc_a), 201);
      clr_a = 1'b1;
      @(posedge clk);
      #1 clr_a = 1'b0;
      chk("clr_acc", int'(acc_a), 0);
      chk("clr_sat", int'(sat_a), 0);
      bus_a.out_ready = 1'b0;
      push(1'b0, 9'd11); push(1'b1, 9'd12);
      chk("t6_count_pre", int'(count_a), 2);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1 chk("t6_out_valid", int'(bus_a.out_valid), 0);
      chk("t6_count", int'(count_a), 0);
      chk("t6_acc", int'(acc_a), 0);
      chk("t6_out_mag", int'(bus_a.out_mag), 0);
      chk("t6_in_ready", int'(bus_a.in_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(1'b1, 9'd256); push(1'b1, 9'd256);
      chk("t6_acc_after", int'(acc_a), -512);
`ifdef ADDER_STATS_EN
      chk("t6_nsat_cnt", int'(nsat_a), 2);
      chk("t6_neg_cnt", int'(neg_a), 2);
`endif
      drain();
      bus_b.out_ready = 1'b1;
      bus_b.in_valid  = 1'b1;
      bus_b.in_sign   = 1'b0;
      bus_b.in_mag    = 9'd255;
      repeat (5) @(posedge clk);
      #1 chk("t5_acc", int'(acc_b), 1023);
      chk("t5_sat", int'(sat_b), 1);
      clr_b = 1'b1;
      bus_b.in_sign = 1'b1;
      bus_b.in_mag  = 9'd256;
      @(posedge clk);
      #1 clr_b = 1'b0;
      bus_b.in_valid = 1'b0;
      chk("t5_clr_push_acc", int'(acc_b), -256);
      chk("t5_clr_push_sat", int'(sat_b), 0);
      chk("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
